ahb_slave_port_arbiter: RTL and testbench
=========================================

Name: ahb_slave_port_arbiter

Overview:
- Per-slave arbiter for the multi-master AHB interconnect.
- Sits in front of the slave-side payload mux and shares one slave between CHANNEL_NUM masters.
- Drives the one-hot address-phase select for the mux and a one-cycle-delayed data-phase select for write-data and response routing.
- Round-robin arbitration, re-arbitrating only at legal AHB boundaries: end of transfer or burst, with HMASTLOCK and HREADY respected.

Parameters:
CHANNEL_NUM, 4, number of masters sharing this slave; range 1..16.

Ports:
hclk  input  1  bus clock, rising edge.
hreset  input  1  asynchronous, active-high reset.
hreq  input  CHANNEL_NUM  master i's address decodes to this slave and its HTRANS is NONSEQ, SEQ or BUSY.
htrans  input  CHANNEL_NUM x 2  per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
hburst  input  CHANNEL_NUM x 3  per-master HBURST (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
hlock  input  CHANNEL_NUM  per-master HMASTLOCK.
hready_in  input  1  HREADYOUT of the slave.
addr_sel  output  CHANNEL_NUM  one-hot or zero; address-phase owner; drives the mux sel.
data_sel  output  CHANNEL_NUM  one-hot or zero; data-phase owner.
hmastlock_out  output  1  HMASTLOCK forwarded to the slave.

Behaviour:
- Reset, asynchronous: addr_sel=0, data_sel=0, hmastlock_out=0, beat counter cnt=0, round-robin pointer last=CHANNEL_NUM-1. Master 0 has first priority.
- States:
  - IDLE: addr_sel==0.
  - OWNED: addr_sel one-hot. Owner index is o.
- Notation: accepted = hready_in==1 and htrans[o] is NONSEQ or SEQ.
- Stall: while hready_in==0, addr_sel, data_sel, cnt and last all hold. Input changes during the stall are ignored.
- data_sel update: on every hclk edge with hready_in==1, data_sel <= accepted ? addr_sel : 0.
- Beat counter, OWNED and hready_in==1 only:
  - NONSEQ loads cnt with len-1: SINGLE 0, fixed 4/8/16 give 3/7/15, INCR loads 0 and sets flag undef=1.
  - SEQ decrements cnt, saturating at 0.
  - BUSY and IDLE leave cnt unchanged.
- Release point, evaluated only when hready_in==1. Owner releases if any of:
  - hreq[o]==0.
  - Accepted NONSEQ with hburst SINGLE.
  - Accepted SEQ with cnt==1, or accepted NONSEQ/SEQ where the new cnt value is 0, for fixed bursts.
- Undefined INCR holds while hreq[o]==1.
- Lock: if hlock[o]==1 and hreq[o]==1, no release, overriding all release rules.
- Arbitration, at a release point or in IDLE, with hready_in==1:
  - addr_sel <= one-hot of the first requester searching last+1, last+2, ... with wrap.
  - last <= that index.
  - If no hreq bit is set, addr_sel <= 0 (IDLE).
  - The releasing master may be re-granted only if no other master requests.
- Latency: a request in IDLE gives addr_sel on the next edge. The first beat is sampled as an address phase in the following cycle.
- Back-to-back: a release point and a new grant happen on the same edge, with no dead cycle.
- hmastlock_out = |(addr_sel & hlock). Combinational.
- Width rules:
  - cnt is 4 bits.
  - last is clog2(CHANNEL_NUM) bits, minimum 1.
  - CHANNEL_NUM=1 degenerates to addr_sel=hreq gated by the release logic.
- Simultaneous events:
  - Owner's hreq drops while another master requests and hready_in==1: switch on that edge.
  - hready_in==0 at the same time: defer switching until hready_in==1.
- Reset mid-burst returns to IDLE immediately. No partial state survives.
- Invariants, to be checked by assertions:
  - addr_sel and data_sel each $onehot0.
  - addr_sel stable while hready_in==0.
  - data_sel equals the previous-cycle addr_sel whenever the previous cycle had hready_in==1 and accepted==1.

Test Plan:
1. Reset then hreq=4'b0110 with SINGLE NONSEQ, hready_in=1 -> addr_sel=0010 one cycle later, then 0100, then 0010. data_sel trails addr_sel by one cycle each.
2. Master 0 INCR4 (NONSEQ, SEQ, SEQ, SEQ) with master 3 requesting throughout -> addr_sel=0001 for exactly 4 accepted beats, 1000 on the edge after the 4th beat.
3. Master 0 INCR4 with hready_in=0 for 3 cycles mid-burst -> addr_sel, data_sel and cnt frozen; burst completes after 4 accepted beats, then master 3 granted.
4. Master 1 undefined INCR with hlock=1 for 6 beats including one BUSY, master 2 requesting -> addr_sel=0010 and hmastlock_out=1 for all 6 beats; master 2 granted only after master 1's hreq drops.
5. All four masters continuously issue SINGLE -> grant order 0,1,2,3,0; no master granted twice before the others are served.
6. Assert hreset in the middle of an INCR8 at beat 5 -> addr_sel=0, data_sel=0 and hmastlock_out=0 asynchronously. After release, master 0 wins first.

Source files
------------

// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave round-robin arbiter for a multi-master AHB interconnect: grants the slave
// address phase to one master and re-arbitrates only at transfer/burst boundaries.
module ahb_slave_port_arbiter #(
  parameter int CHANNEL_NUM = 4
) (
  input  logic                        hclk,
  input  logic                        hreset,
  input  logic [CHANNEL_NUM-1:0]      hreq,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic [CHANNEL_NUM-1:0][2:0] hburst,
  input  logic [CHANNEL_NUM-1:0]      hlock,
  input  logic                        hready_in,
  output logic [CHANNEL_NUM-1:0]      addr_sel,
  output logic [CHANNEL_NUM-1:0]      data_sel,
  output logic                        hmastlock_out
);

  localparam int LW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BU_INCR   = 3'd1;

  typedef enum logic {ST_IDLE = 1'b0, ST_OWNED = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [CHANNEL_NUM-1:0] addr_sel_q, addr_sel_d;
  logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   undef_q, undef_d;
  logic [LW-1:0]          last_q, last_d;

  logic [LW-1:0]          owner_s, pick_idx_s, rot_idx_s;
  logic [LW:0]            rot_sum_s;
  logic                   pick_found_s;
  logic [1:0]             o_trans_s;
  logic [2:0]             o_burst_s;
  logic                   o_req_s, o_lock_s;
  logic                   accepted_s, release_s;

  // Remaining beats after the NONSEQ; SINGLE and undefined INCR both load zero.
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_beats_m1 = 4'd3;
      3'd4, 3'd5: burst_beats_m1 = 4'd7;
      3'd6, 3'd7: burst_beats_m1 = 4'd15;
      default:    burst_beats_m1 = 4'd0;
    endcase
  endfunction

  always_comb begin
    owner_s = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      owner_s = owner_s | (addr_sel_q[i] ? LW'(i) : '0);
    end
    o_trans_s = htrans[owner_s];
    o_burst_s = hburst[owner_s];
    o_req_s   = hreq[owner_s];
    o_lock_s  = hlock[owner_s];
  end

  // Search last+1, last+2, ... with wrap; the previous owner is examined last.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = last_q;
    rot_sum_s    = '0;
    rot_idx_s    = '0;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      rot_sum_s = {1'b0, last_q} + (LW+1)'(k);
      rot_sum_s = (rot_sum_s >= (LW+1)'(CHANNEL_NUM)) ? rot_sum_s - (LW+1)'(CHANNEL_NUM) : rot_sum_s;
      rot_idx_s = rot_sum_s[LW-1:0];
      pick_idx_s   = (!pick_found_s && hreq[rot_idx_s]) ? rot_idx_s : pick_idx_s;
      pick_found_s = pick_found_s | hreq[rot_idx_s];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_sel_d = addr_sel_q;
    data_sel_d = data_sel_q;
    cnt_d      = cnt_q;
    undef_d    = undef_q;
    last_d     = last_q;
    release_s  = 1'b0;
    accepted_s = (state_q == ST_OWNED) && hready_in && o_trans_s[1];

    if (hready_in) begin
      data_sel_d = accepted_s ? addr_sel_q : '0;
      if (state_q == ST_OWNED) begin
        case (o_trans_s)
          TR_NONSEQ: begin
            cnt_d   = burst_beats_m1(o_burst_s);
            undef_d = (o_burst_s == BU_INCR);
          end
          TR_SEQ:  cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          default: cnt_d = cnt_q;
        endcase
        // A locked, still-requesting owner is never released.
        release_s = (!o_req_s || (accepted_s && !undef_d && (cnt_d == 4'd0)))
                    && !(o_lock_s && o_req_s);
      end else begin
        release_s = 1'b1;
      end

      if (release_s) begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
          addr_sel_d[i] = pick_found_s && (LW'(i) == pick_idx_s);
        end
        last_d  = pick_found_s ? pick_idx_s : last_q;
        state_d = pick_found_s ? ST_OWNED : ST_IDLE;
      end else begin
        state_d = state_q;
      end
    end else begin
      data_sel_d = data_sel_q;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= ST_IDLE;
      addr_sel_q <= '0;
      data_sel_q <= '0;
      cnt_q      <= 4'd0;
      undef_q    <= 1'b0;
      last_q     <= LW'(CHANNEL_NUM - 1);
    end else begin
      state_q    <= state_d;
      addr_sel_q <= addr_sel_d;
      data_sel_q <= data_sel_d;
      cnt_q      <= cnt_d;
      undef_q    <= undef_d;
      last_q     <= last_d;
    end
  end

  assign addr_sel      = addr_sel_q;
  assign data_sel      = data_sel_q;
  assign hmastlock_out = |(addr_sel_q & hlock);

endmodule

// Invariant checker for ahb_slave_port_arbiter; observes only its ports.
module ahb_slave_port_arbiter_chk #(
  parameter int CHANNEL_NUM = 4
) (
  input logic                        hclk,
  input logic                        hreset,
  input logic [CHANNEL_NUM-1:0][1:0] htrans,
  input logic                        hready_in,
  input logic [CHANNEL_NUM-1:0]      addr_sel,
  input logic [CHANNEL_NUM-1:0]      data_sel
);

  logic                   prev_valid_q, prev_acc_q, prev_stall_q, prev_acc_d;
  logic [CHANNEL_NUM-1:0] prev_addr_q, xfer_mask_s;

  always_comb begin
    xfer_mask_s = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      xfer_mask_s[i] = (htrans[i] == 2'd2) || (htrans[i] == 2'd3);
    end
    prev_acc_d = hready_in && (|(addr_sel & xfer_mask_s));
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      prev_valid_q <= 1'b0;
      prev_acc_q   <= 1'b0;
      prev_stall_q <= 1'b0;
      prev_addr_q  <= '0;
    end else begin
      prev_valid_q <= 1'b1;
      prev_acc_q   <= prev_acc_d;
      prev_stall_q <= !hready_in;
      prev_addr_q  <= addr_sel;
    end
  end

  a_addr_onehot0: assert property (@(negedge hclk) $onehot0(addr_sel));
  a_data_onehot0: assert property (@(negedge hclk) $onehot0(data_sel));
  a_addr_stall:   assert property (@(negedge hclk)
                    (!hreset && prev_valid_q && prev_stall_q) |-> (addr_sel == prev_addr_q));
  a_data_follow:  assert property (@(negedge hclk)
                    (!hreset && prev_valid_q && prev_acc_q) |-> (data_sel == prev_addr_q));

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Vector-table bench for ahb_slave_port_arbiter: each vector queues the outputs
// expected after its clock edge; a negedge monitor pops and compares them.
module tb_ahb_slave_port_arbiter;

  logic             hclk = 1'b0;
  logic             hreset;
  logic [3:0]       hreq;
  logic [3:0][1:0]  htrans;
  logic [3:0][2:0]  hburst;
  logic [3:0]       hlock;
  logic             hready_in;
  logic [3:0]       addr_sel, data_sel;
  logic             hmastlock_out;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  trans;
    logic [11:0] burst;
    logic [3:0]  lock;
    logic        rdy;
    logic [3:0]  exp_addr;
    logic [3:0]  exp_data;
    logic        exp_lock;
  } vec_t;

  typedef struct {
    int         tag;
    logic [3:0] addr;
    logic [3:0] data;
    logic       lk;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   test_id  = 0;

  always #5 hclk = ~hclk;

  ahb_slave_port_arbiter #(.CHANNEL_NUM(4)) dut (
    .hclk(hclk), .hreset(hreset), .hreq(hreq), .htrans(htrans), .hburst(hburst),
    .hlock(hlock), .hready_in(hready_in), .addr_sel(addr_sel), .data_sel(data_sel),
    .hmastlock_out(hmastlock_out)
  );

  ahb_slave_port_arbiter_chk #(.CHANNEL_NUM(4)) u_chk (
    .hclk(hclk), .hreset(hreset), .htrans(htrans), .hready_in(hready_in),
    .addr_sel(addr_sel), .data_sel(data_sel)
  );

  task automatic chk(input string name, input int tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s tag=%0d got=%b expected=%b", name, tag, act, exp);
    end
  endtask

  always @(negedge hclk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("addr_sel", e.tag, addr_sel, e.addr);
      chk("data_sel", e.tag, data_sel, e.data);
      chk("hmastlock_out", e.tag, {3'b000, hmastlock_out}, {3'b000, e.lk});
    end
  end

  task automatic add(input logic [3:0] req, input logic [7:0] trans, input logic [11:0] burst,
                     input logic [3:0] lock, input logic rdy, input logic [3:0] ea,
                     input logic [3:0] ed, input logic el);
    vec_t v;
    v.req = req; v.trans = trans; v.burst = burst; v.lock = lock; v.rdy = rdy;
    v.exp_addr = ea; v.exp_data = ed; v.exp_lock = el;
    vecs.push_back(v);
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge hclk); #1;
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain test=%0d pending=%0d expected=0", test_id, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_vecs();
    vec_t v;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge hclk); #1;
      hreq = v.req; htrans = v.trans; hburst = v.burst; hlock = v.lock; hready_in = v.rdy;
      exp_q.push_back('{test_id * 100 + i, v.exp_addr, v.exp_data, v.exp_lock});
    end
    vecs.delete();
    drain();
  endtask

  task automatic zero_inputs();
    hreq = 4'h0; htrans = 8'h00; hburst = 12'h000; hlock = 4'h0; hready_in = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge hclk); #1;
    zero_inputs();
    hreset = 1'b1;
    #1;
    chk("rst_addr_sel", test_id, addr_sel, 4'b0000);
    chk("rst_data_sel", test_id, data_sel, 4'b0000);
    chk("rst_hmastlock", test_id, {3'b000, hmastlock_out}, 4'b0000);
    @(negedge hclk); #1;
    hreset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    hreset = 1'b1;
    zero_inputs();

    // 1: two SINGLE requesters alternate, data_sel trails by one cycle
    test_id = 1;
    do_reset();
    add(4'b0110, 8'h28, 12'h000, 4'h0, 1'b1, 4'b0010, 4'b0000, 1'b0);
    add(4'b0110, 8'h28, 12'h000, 4'h0, 1'b1, 4'b0100, 4'b0010, 1'b0);
    add(4'b0110, 8'h28, 12'h000, 4'h0, 1'b1, 4'b0010, 4'b0100, 1'b0);
    add(4'b0110, 8'h28, 12'h000, 4'h0, 1'b1, 4'b0100, 4'b0010, 1'b0);
    add(4'b0000, 8'h00, 12'h000, 4'h0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 8'h00, 12'h000, 4'h0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    run_vecs();

    // 2: master 0 INCR4 holds the slave for 4 beats, then master 3 back-to-back
    test_id = 2;
    do_reset();
    add(4'b1001, 8'h82, 12'h003, 4'h0, 1'b1, 4'b0001, 4'b0000, 1'b0);
    add(4'b1001, 8'h82, 12'h003, 4'h0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    add(4'b1001, 8'h83, 12'h003, 4'h0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    add(4'b1001, 8'h83, 12'h003, 4'h0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    add(4'b1001, 8'h83, 12'h003, 4'h0, 1'b1, 4'b1000, 4'b0001, 1'b0);
    add(4'b1000, 8'h80, 12'h000, 4'h0, 1'b1, 4'b1000, 4'b1000, 1'b0);
    add(4'b0000, 8'h00, 12'h000, 4'h0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    run_vecs();

    // 3: INCR4 with a 3-cycle wait state; hreq drop during the stall is ignored
    test_id = 3;
    do_reset();
    add(4'b1001, 8'h82, 12'h003, 4'h0, 1'b1, 4'b0001, 4'b0000, 1'b0);
    add(4'b1001, 8'h82, 12'h003, 4'h0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    add(4'b1001, 8'h83, 12'h003, 4'h0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    add(4'b1001, 8'h83, 12'h003, 4'h0, 1'b0, 4'b0001, 4'b0001, 1'b0);
    add(4'b1000, 8'h80, 12'h003, 4'h0, 1'b0, 4'b0001, 4'b0001, 1'b0);
    add(4'b1001, 8'h83, 12'h003, 4'h0, 1'b0, 4'b0001, 4'b0001, 1'b0);
    add(4'b1001, 8'h83, 12'h003, 4'h0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    add(4'b1001, 8'h83, 12'h003, 4'h0, 1'b1, 4'b1000, 4'b0001, 1'b0);
    add(4'b1000, 8'h80, 12'h000, 4'h0, 1'b1, 4'b1000, 4'b1000, 1'b0);
    add(4'b0000, 8'h00, 12'h000, 4'h0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    run_vecs();

    // 4: locked undefined INCR on master 1 with a BUSY beat; master 2 waits
    test_id = 4;
    do_reset();
    add(4'b0110, 8'h28, 12'h008, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1);
    add(4'b0110, 8'h28, 12'h008, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1);
    add(4'b0110, 8'h2C, 12'h008, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1);
    add(4'b0110, 8'h2C, 12'h008, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1);
    add(4'b0110, 8'h24, 12'h008, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1);
    add(4'b0110, 8'h2C, 12'h008, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1);
    add(4'b0110, 8'h2C, 12'h008, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1);
    add(4'b0100, 8'h20, 12'h008, 4'b0010, 1'b1, 4'b0100, 4'b0000, 1'b0);
    add(4'b0000, 8'h00, 12'h000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);
    run_vecs();

    // 5: all masters issue SINGLE continuously -> strict rotation 0,1,2,3,0
    test_id = 5;
    do_reset();
    add(4'b1111, 8'hAA, 12'h000, 4'h0, 1'b1, 4'b0001, 4'b0000, 1'b0);
    add(4'b1111, 8'hAA, 12'h000, 4'h0, 1'b1, 4'b0010, 4'b0001, 1'b0);
    add(4'b1111, 8'hAA, 12'h000, 4'h0, 1'b1, 4'b0100, 4'b0010, 1'b0);
    add(4'b1111, 8'hAA, 12'h000, 4'h0, 1'b1, 4'b1000, 4'b0100, 1'b0);
    add(4'b1111, 8'hAA, 12'h000, 4'h0, 1'b1, 4'b0001, 4'b1000, 1'b0);
    add(4'b0000, 8'h00, 12'h000, 4'h0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    run_vecs();

    // 6: locked INCR8 on master 0, asynchronous reset after beat 5
    test_id = 6;
    do_reset();
    add(4'b0011, 8'h0A, 12'h005, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1);
    add(4'b0011, 8'h0A, 12'h005, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);
    add(4'b0011, 8'h0B, 12'h005, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);
    add(4'b0011, 8'h0B, 12'h005, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);
    add(4'b0011, 8'h0B, 12'h005, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);
    add(4'b0011, 8'h0B, 12'h005, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);
    run_vecs();
    hreset = 1'b1;
    #1;
    chk("async_rst_addr_sel", 600, addr_sel, 4'b0000);
    chk("async_rst_data_sel", 600, data_sel, 4'b0000);
    chk("async_rst_hmastlock", 600, {3'b000, hmastlock_out}, 4'b0000);
    zero_inputs();
    @(negedge hclk); #1;
    hreset = 1'b0;
    test_id = 7;
    add(4'b0011, 8'h0A, 12'h000, 4'h0, 1'b1, 4'b0001, 4'b0000, 1'b0);
    add(4'b0011, 8'h0A, 12'h000, 4'h0, 1'b1, 4'b0010, 4'b0001, 1'b0);
    add(4'b0000, 8'h00, 12'h000, 4'h0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    run_vecs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
